// File: rtl/pma_arb_pkg.sv
// Shared types and constants for the PMA checker arbiter.
package pma_arb_pkg;

  typedef enum logic [1:0] {IDLE, CHECK, RESP} statetype;

  localparam int unsigned REQ_HPTW = 0;
  localparam int unsigned REQ_LSU  = 1;
  localparam int unsigned REQ_IFU  = 2;

  typedef enum logic [2:0] {
    ACC_READ   = 3'b000,
    ACC_WRITE  = 3'b001,
    ACC_EXEC   = 3'b010,
    ACC_ATOMIC = 3'b011,
    ACC_CMO    = 3'b100
  } accesstype;

  localparam logic [3:0] CMO_OP = 4'b0001;

  // Picks the fault flavour that matters for the access being checked.
  function automatic logic sel_fault(input accesstype t, input logic instr_f,
                                     input logic load_f, input logic store_f);
    if (t == ACC_EXEC) return instr_f;
    if (t == ACC_READ) return load_f;
    return store_f;
  endfunction

endpackage

// File: rtl/pma_arb_prio.sv
// Fixed-priority selector (HPTW > LSU > IFU) with IFU starvation promotion.
module pma_arb_prio
  import pma_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       arb_en_i,
  input  logic [2:0] req_i,
  input  logic       ifu_flush_i,
  output logic [2:0] gnt_o,
  output logic [1:0] idx_o
);

  logic [3:0] starve_q, starve_d;
  logic [2:0] req_eff;
  logic       ifu_promote;

  assign req_eff     = {req_i[REQ_IFU] & ~ifu_flush_i, req_i[REQ_LSU], req_i[REQ_HPTW]};
  assign ifu_promote = req_eff[REQ_IFU] && (starve_q >= 4'(STARVE_LIMIT));

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    if (arb_en_i) begin
      if (ifu_promote) begin
        gnt_o[REQ_IFU] = 1'b1;
        idx_o          = 2'(REQ_IFU);
      end else if (req_eff[REQ_HPTW]) begin
        gnt_o[REQ_HPTW] = 1'b1;
        idx_o           = 2'(REQ_HPTW);
      end else if (req_eff[REQ_LSU]) begin
        gnt_o[REQ_LSU] = 1'b1;
        idx_o          = 2'(REQ_LSU);
      end else if (req_eff[REQ_IFU]) begin
        gnt_o[REQ_IFU] = 1'b1;
        idx_o          = 2'(REQ_IFU);
      end
    end
  end

  // A flushed IFU request is neither a loss nor an absence: the count holds.
  always_comb begin
    starve_d = starve_q;
    if (arb_en_i && !(req_i[REQ_IFU] && ifu_flush_i)) begin
      if (req_eff[REQ_IFU] && !gnt_o[REQ_IFU]) begin
        starve_d = (starve_q == 4'd15) ? 4'd15 : starve_q + 4'd1;
      end else begin
        starve_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

endmodule

// File: rtl/pma_check_arbiter.sv
// Time-shares one combinational PMA checker between HPTW, LSU and IFU.
module pma_check_arbiter
  import pma_arb_pkg::*;
#(
  parameter int unsigned PA_BITS      = 56,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           Req,
  input  logic [3*PA_BITS-1:0] ReqAddr,
  input  logic [5:0]           ReqSize,
  input  logic [8:0]           ReqType,
  output logic [2:0]           Gnt,
  input  logic                 FlushF,
  output logic                 RspValid,
  output logic [1:0]           RspId,
  input  logic                 RspReady,
  output logic                 RspFault,
  output logic                 RspCacheable,
  output logic                 RspIdempotent,
  output logic                 RspSelTIM,
  output logic [PA_BITS-1:0]   ChkAddr,
  output logic [1:0]           ChkSize,
  output logic                 ChkRead,
  output logic                 ChkWrite,
  output logic                 ChkExec,
  output logic                 ChkAtomic,
  output logic [3:0]           ChkCMOp,
  input  logic                 ChkCacheable,
  input  logic                 ChkIdempotent,
  input  logic                 ChkSelTIM,
  input  logic                 ChkInstrFault,
  input  logic                 ChkLoadFault,
  input  logic                 ChkStoreFault
);

  statetype             state_q, state_d;
  logic [1:0]           owner_q;
  logic [PA_BITS-1:0]   addr_q;
  logic [1:0]           size_q;
  accesstype            type_q;
  logic                 fault_q, cach_q, idem_q, tim_q;

  logic [2:0]           win_gnt;
  logic [1:0]           win_idx;
  logic                 ifu_flush;
  logic [PA_BITS-1:0]   req_addr [3];
  logic [1:0]           req_size [3];
  logic [2:0]           req_type [3];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      req_addr[i] = ReqAddr[i*PA_BITS +: PA_BITS];
      req_size[i] = ReqSize[i*2 +: 2];
      req_type[i] = ReqType[i*3 +: 3];
    end
  end

  pma_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk        (clk),
    .reset      (reset),
    .arb_en_i   (state_q == IDLE),
    .req_i      (Req),
    .ifu_flush_i(FlushF),
    .gnt_o      (win_gnt),
    .idx_o      (win_idx)
  );

  assign ifu_flush = FlushF && (owner_q == 2'(REQ_IFU));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|win_gnt) state_d = CHECK;
      CHECK:   state_d = ifu_flush ? IDLE : RESP;
      RESP:    if (ifu_flush || RspReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      type_q  <= ACC_READ;
      fault_q <= 1'b0;
      cach_q  <= 1'b0;
      idem_q  <= 1'b0;
      tim_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && |win_gnt) begin
        owner_q <= win_idx;
        addr_q  <= req_addr[win_idx];
        size_q  <= req_size[win_idx];
        type_q  <= accesstype'(req_type[win_idx]);
      end
      if (state_q == CHECK && !ifu_flush) begin
        fault_q <= sel_fault(type_q, ChkInstrFault, ChkLoadFault, ChkStoreFault);
        cach_q  <= ChkCacheable;
        idem_q  <= ChkIdempotent;
        tim_q   <= ChkSelTIM;
      end
    end
  end

  always_comb begin
    Gnt           = win_gnt;
    RspValid      = (state_q == RESP);
    RspId         = owner_q;
    RspFault      = fault_q;
    RspCacheable  = cach_q;
    RspIdempotent = idem_q;
    RspSelTIM     = tim_q;
    ChkAddr       = addr_q;
    ChkSize       = size_q;
    ChkRead       = 1'b0;
    ChkWrite      = 1'b0;
    ChkExec       = 1'b0;
    ChkAtomic     = 1'b0;
    ChkCMOp       = 4'b0000;
    if (state_q == CHECK) begin
      unique case (type_q)
        ACC_READ:   ChkRead = 1'b1;
        ACC_WRITE:  ChkWrite = 1'b1;
        ACC_EXEC:   ChkExec = 1'b1;
        ACC_ATOMIC: begin
          ChkRead   = 1'b1;
          ChkWrite  = 1'b1;
          ChkAtomic = 1'b1;
        end
        ACC_CMO:    ChkCMOp = CMO_OP;
        default:    ;
      endcase
    end
  end

endmodule

// File: tb/tb_pma_check_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction model.
module tb_pma_check_arbiter;

  localparam int PA  = 56;
  localparam int LIM = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [2:0]      Req;
  logic [3*PA-1:0] ReqAddr;
  logic [5:0]      ReqSize;
  logic [8:0]      ReqType;
  logic [2:0]      Gnt;
  logic            FlushF, RspValid, RspReady;
  logic [1:0]      RspId;
  logic            RspFault, RspCacheable, RspIdempotent, RspSelTIM;
  logic [PA-1:0]   ChkAddr;
  logic [1:0]      ChkSize;
  logic            ChkRead, ChkWrite, ChkExec, ChkAtomic;
  logic [3:0]      ChkCMOp;
  logic            ChkCacheable, ChkIdempotent, ChkSelTIM;
  logic            ChkInstrFault, ChkLoadFault, ChkStoreFault;

  always #5 clk = ~clk;

  pma_check_arbiter #(.PA_BITS(PA), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset), .Req(Req), .ReqAddr(ReqAddr), .ReqSize(ReqSize),
    .ReqType(ReqType), .Gnt(Gnt), .FlushF(FlushF), .RspValid(RspValid), .RspId(RspId),
    .RspReady(RspReady), .RspFault(RspFault), .RspCacheable(RspCacheable),
    .RspIdempotent(RspIdempotent), .RspSelTIM(RspSelTIM), .ChkAddr(ChkAddr),
    .ChkSize(ChkSize), .ChkRead(ChkRead), .ChkWrite(ChkWrite), .ChkExec(ChkExec),
    .ChkAtomic(ChkAtomic), .ChkCMOp(ChkCMOp), .ChkCacheable(ChkCacheable),
    .ChkIdempotent(ChkIdempotent), .ChkSelTIM(ChkSelTIM), .ChkInstrFault(ChkInstrFault),
    .ChkLoadFault(ChkLoadFault), .ChkStoreFault(ChkStoreFault)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Transaction model: one in-flight check, aged in cycles since its grant.
  bit          m_act = 0;
  int          m_age = 0;
  int          m_own = 0;
  logic [PA-1:0] m_addr;
  logic [1:0]  m_size;
  logic [2:0]  m_type;
  bit          m_flt, m_cac, m_idm, m_tim;
  int          m_starve = 0;
  logic [2:0]  last_eg;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int winner();
    if (m_act) return -1;
    if (Req[2] && !FlushF && m_starve >= LIM) return 2;
    if (Req[0]) return 0;
    if (Req[1]) return 1;
    if (Req[2] && !FlushF) return 2;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [PA-1:0] a, input logic [1:0] s,
                         input logic [2:0] t);
    ReqAddr[i*PA +: PA] = a;
    ReqSize[i*2 +: 2]   = s;
    ReqType[i*3 +: 3]   = t;
  endtask

  task automatic clear_inputs();
    Req = '0; ReqAddr = '0; ReqSize = '0; ReqType = '0; FlushF = 0; RspReady = 0;
    ChkCacheable = 0; ChkIdempotent = 0; ChkSelTIM = 0;
    ChkInstrFault = 0; ChkLoadFault = 0; ChkStoreFault = 0;
  endtask

  // Compare DUT against the model for this cycle, then advance both by one clock.
  task automatic step();
    int  w;
    bit  checking, resp, fl;
    logic [2:0] eg;
    #1;
    w  = winner();
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    last_eg  = eg;
    checking = m_act && m_age == 1;
    resp     = m_act && m_age >= 2;
    chk("gnt", Gnt, eg);
    chk("rsp_valid", RspValid, resp);
    chk("chk_read", ChkRead, checking && (m_type == 3'd0 || m_type == 3'd3));
    chk("chk_write", ChkWrite, checking && (m_type == 3'd1 || m_type == 3'd3));
    chk("chk_exec", ChkExec, checking && m_type == 3'd2);
    chk("chk_atomic", ChkAtomic, checking && m_type == 3'd3);
    chk("chk_cmop", ChkCMOp, (checking && m_type == 3'd4) ? 4'b0001 : 4'b0000);
    if (checking) begin
      chk("chk_addr", ChkAddr, m_addr);
      chk("chk_size", ChkSize, m_size);
    end
    if (resp) begin
      chk("rsp_id", RspId, m_own);
      chk("rsp_fault", RspFault, m_flt);
      chk("rsp_cacheable", RspCacheable, m_cac);
      chk("rsp_idempotent", RspIdempotent, m_idm);
      chk("rsp_seltim", RspSelTIM, m_tim);
    end
    @(posedge clk);
    fl = FlushF && m_own == 2;
    if (reset) begin
      m_act = 0; m_starve = 0; m_own = 0;
    end else if (!m_act) begin
      if (!(Req[2] && FlushF)) begin
        if (Req[2] && w != 2) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
        else m_starve = 0;
      end
      if (w >= 0) begin
        m_act = 1; m_age = 1; m_own = w;
        m_addr = ReqAddr[w*PA +: PA];
        m_size = ReqSize[w*2 +: 2];
        m_type = ReqType[w*3 +: 3];
      end
    end else if (m_age == 1) begin
      if (fl) m_act = 0;
      else begin
        m_flt = (m_type == 3'd2) ? ChkInstrFault :
                (m_type == 3'd0) ? ChkLoadFault : ChkStoreFault;
        m_cac = ChkCacheable; m_idm = ChkIdempotent; m_tim = ChkSelTIM;
        m_age = 2;
      end
    end else begin
      if (fl || RspReady) m_act = 0;
      else m_age++;
    end
    #1;
  endtask

  logic [2:0] gv [5];
  int         gc [5];
  int         ng;
  logic [2:0] pend;

  initial begin
    clear_inputs();
    reset = 1;
    step(); step();
    reset = 0;
    #1;
    chk("reset_rsp_valid", RspValid, 0);
    chk("reset_gnt", Gnt, 0);
    chk("reset_chk_read", ChkRead, 0);
    chk("reset_rsp_fault", RspFault, 0);

    // LSU read, latency N / N+1 / N+2
    set_req(1, 56'h8000_0000, 2'd2, 3'd0);
    Req = 3'b010; ChkCacheable = 1;
    #1 chk("t1_gnt", Gnt, 3'b010);
    step(); Req = 0;
    #1 chk("t1_chk_read", ChkRead, 1);
    chk("t1_chk_addr", ChkAddr, 56'h8000_0000);
    step();
    #1 chk("t1_rsp_valid", RspValid, 1);
    chk("t1_rsp_id", RspId, 1);
    chk("t1_rsp_cacheable", RspCacheable, 1);
    RspReady = 1; step(); RspReady = 0; ChkCacheable = 0;

    // All three at once, ready tied high
    for (int i = 0; i < 3; i++) set_req(i, 56'h1000 * (i + 1), 2'd3, 3'd0);
    pend = 3'b111; RspReady = 1; ng = 0;
    for (int c = 0; c < 12; c++) begin
      Req = pend;
      #1;
      if (|Gnt) begin
        if (ng < 5) begin gv[ng] = Gnt; gc[ng] = c; end
        ng++;
        pend = pend & ~Gnt;
      end
      step();
    end
    Req = 0;
    chk("t2_count", ng, 3);
    chk("t2_g0", gv[0], 3'b001); chk("t2_c0", gc[0], 0);
    chk("t2_g1", gv[1], 3'b010); chk("t2_c1", gc[1], 3);
    chk("t2_g2", gv[2], 3'b100); chk("t2_c2", gc[2], 6);

    // Starvation: IFU always requesting, LSU always re-requesting
    set_req(1, 56'h2000, 2'd0, 3'd1);
    set_req(2, 56'h3000, 2'd0, 3'd2);
    Req = 3'b110; ng = 0;
    for (int c = 0; c < 15 && ng < 5; c++) begin
      #1;
      if (|Gnt) begin gv[ng] = Gnt; ng++; end
      step();
    end
    Req = 0;
    chk("t3_count", ng, 5);
    for (int k = 0; k < 4; k++) chk("t3_lsu_wins", gv[k], 3'b010);
    chk("t3_ifu_fifth", gv[4], 3'b100);
    step(); step(); step();
    RspReady = 0;

    // IFU execute with instruction fault
    set_req(2, 56'h4000, 2'd1, 3'd2); Req = 3'b100; ChkInstrFault = 1;
    #1 chk("t4_gnt", Gnt, 3'b100);
    step(); Req = 0;
    #1 chk("t4_chk_exec", ChkExec, 1);
    step();
    #1 chk("t4_rsp_fault", RspFault, 1);
    RspReady = 1; step(); RspReady = 0; ChkInstrFault = 0;

    // LSU atomic with store fault
    set_req(1, 56'h5000, 2'd2, 3'd3); Req = 3'b010; ChkStoreFault = 1;
    step(); Req = 0;
    #1 chk("t4_atomic_read", ChkRead, 1);
    chk("t4_atomic_write", ChkWrite, 1);
    chk("t4_atomic_amo", ChkAtomic, 1);
    step();
    #1 chk("t4_atomic_fault", RspFault, 1);
    RspReady = 1; step(); RspReady = 0; ChkStoreFault = 0;

    // Flush during IFU CHECK, then flush during LSU has no effect
    set_req(2, 56'h6000, 2'd0, 3'd2); Req = 3'b100;
    step(); Req = 0; FlushF = 1;
    step(); FlushF = 0;
    set_req(0, 56'h7000, 2'd0, 3'd0); Req = 3'b001;
    #1 chk("t5_no_rsp", RspValid, 0);
    chk("t5_idle_gnt", Gnt, 3'b001);
    step(); Req = 0; step();
    RspReady = 1; step(); RspReady = 0;
    set_req(1, 56'h7100, 2'd0, 3'd0); Req = 3'b010;
    step(); Req = 0; FlushF = 1;
    step();
    #1 chk("t5_lsu_valid", RspValid, 1);
    chk("t5_lsu_id", RspId, 1);
    RspReady = 1; step(); RspReady = 0; FlushF = 0;

    // Backpressure for 5 cycles, then reset in RESP
    set_req(1, 56'h7200, 2'd1, 3'd0); Req = 3'b010; ChkIdempotent = 1; ChkSelTIM = 1;
    step(); Req = 0; step();
    ChkIdempotent = 0; ChkSelTIM = 0;
    for (int k = 0; k < 5; k++) begin
      #1 chk("t6_hold_valid", RspValid, 1);
      chk("t6_hold_idem", RspIdempotent, 1);
      chk("t6_hold_tim", RspSelTIM, 1);
      step();
    end
    reset = 1; step(); reset = 0;
    #1 chk("t6_reset_valid", RspValid, 0);
    Req = 3'b010;
    #1 chk("t6_reset_idle_gnt", Gnt, 3'b010);
    step(); Req = 0; step(); RspReady = 1; step(); RspReady = 0;

    // Randomized traffic
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          set_req(i, {$urandom, $urandom}, 2'($urandom), 3'($urandom_range(0, 4)));
        end
      end
      reset         = ($urandom_range(0, 149) == 0);
      Req           = reset ? 3'b000 : pend;
      FlushF        = ($urandom_range(0, 7) == 0);
      RspReady      = $urandom_range(0, 1) == 1;
      ChkCacheable  = $urandom_range(0, 1) == 1;
      ChkIdempotent = $urandom_range(0, 1) == 1;
      ChkSelTIM     = $urandom_range(0, 1) == 1;
      ChkInstrFault = $urandom_range(0, 1) == 1;
      ChkLoadFault  = $urandom_range(0, 1) == 1;
      ChkStoreFault = $urandom_range(0, 1) == 1;
      step();
      pend = pend & ~last_eg;
    end
    reset = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pma_check_arbiter.md
Name: pma_check_arbiter

Overview:
- Time-shares one physical-memory-attribute checker (combinational PMA/address-decode unit) between three requesters: HPTW page-table walker, LSU and IFU.
- Arbitrates, registers the winning request, drives the checker inputs for one cycle, captures its attributes/faults, and returns a response through a valid/ready handshake.
- Sits in the MMU between the requesters and the shared checker instance.

Parameters:
- PA_BITS, 56, physical address width.
- STARVE_LIMIT, 4, consecutive lost arbitrations by a requesting IFU before it is promoted to top priority (range 1..15).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- Req  in  3  request per requester; index 0=HPTW, 1=LSU, 2=IFU
- ReqAddr  in  3*PA_BITS  physical address per requester; slice i belongs to requester i
- ReqSize  in  3*2  access size per requester
- ReqType  in  3*3  access type per requester: 000 read, 001 write, 010 execute, 011 atomic, 100 CMO
- Gnt  out  3  one-hot; request accepted this cycle
- FlushF  in  1  cancels any IFU-owned transaction
- RspValid  out  1  response valid
- RspId  out  2  owner index of the response
- RspReady  in  1  owner consumes response
- RspFault, RspCacheable, RspIdempotent, RspSelTIM  out  1 each  captured results
- ChkAddr  out  PA_BITS  checker address
- ChkSize  out  2  checker size
- ChkRead, ChkWrite, ChkExec, ChkAtomic  out  1 each  checker access strobes
- ChkCMOp  out  4  checker CMO op; 0001 for a CMO request, else 0000
- ChkCacheable, ChkIdempotent, ChkSelTIM, ChkInstrFault, ChkLoadFault, ChkStoreFault  in  1 each  checker results

Behaviour:
- FSM states: IDLE, CHECK, RESP. Reset: state IDLE; Gnt=0; RspValid=0; all Rsp* outputs 0; all Chk* strobes 0; starve counter 0.
- IDLE:
  - If any Req bit is set: assert Gnt to the winner combinationally in that cycle.
  - Latch the winner's Addr, Size, Type and Id. Next state CHECK.
  - No Req: stay in IDLE.
  - Gnt is never asserted outside IDLE.
- Priority: HPTW > LSU > IFU, except that IFU wins when StarveCnt >= STARVE_LIMIT.
- Starve counter:
  - Increments, saturating at 15, each IDLE arbitration in which IFU requests but loses.
  - Clears when IFU wins or does not request.
- CHECK:
  - Drive Chk* from the latched request: read→ChkRead, write→ChkWrite, execute→ChkExec, atomic→ChkRead+ChkWrite+ChkAtomic, CMO→ChkCMOp=0001.
  - At the cycle's end, capture results into the Rsp* registers. Next state RESP.
  - Chk* strobes are 0 in every other state; ChkAddr holds the latched value.
- Fault select by latched type:
  - execute → ChkInstrFault
  - read → ChkLoadFault
  - write, atomic or CMO → ChkStoreFault
- RESP:
  - RspValid=1, with RspId and Rsp* stable until RspReady.
  - RspValid & RspReady → IDLE in the next cycle. A new grant is possible in that IDLE cycle, so throughput is one check per 3 cycles.
- Latency: Gnt in cycle N; RspValid rises in cycle N+2.
- FlushF, when the latched owner is IFU:
  - In CHECK: return to IDLE with no response.
  - In RESP: drop RspValid and return to IDLE.
  - FlushF in IDLE suppresses the IFU grant that cycle; the IFU loss is not counted for starvation.
  - FlushF has no effect on HPTW or LSU transactions.
- Simultaneous RspReady and FlushF on an IFU response: the flush wins; no handshake is recorded.
- Requester inputs are ignored outside IDLE; requesters hold Req until Gnt.
- Reset mid-transaction: returns to IDLE immediately; the pending response is lost.

Decomposition:
- Package pma_arb_pkg holds:
  - statetype enum {IDLE, CHECK, RESP}
  - requester index constants REQ_HPTW=0, REQ_LSU=1, REQ_IFU=2
  - accesstype enum (3-bit encoding above)
  - CMO_OP constant 4'b0001
- Sub-module pma_arb_prio contains the fixed-priority selector plus the IFU starvation counter. Outputs: one-hot grant and winner index.

Test Plan:
- Reset, then LSU read to 0x8000_0000 with ChkCacheable=1 → Gnt=010 at N; ChkRead=1 at N+1; RspValid, RspId=1, RspCacheable=1 at N+2.
- HPTW, LSU and IFU all requesting in the same cycle → grants in order HPTW, LSU, IFU; each response held until RspReady; 3-cycle spacing when RspReady is tied high.
- STARVE_LIMIT=4; IFU requests continuously while LSU re-requests every IDLE → IFU loses 4 times, then wins the 5th arbitration despite the LSU request.
- IFU execute with ChkInstrFault=1 → RspFault=1. LSU atomic with ChkStoreFault=1 → ChkRead=ChkWrite=ChkAtomic=1 in CHECK and RspFault=1.
- FlushF asserted in CHECK of an IFU request → no RspValid, back in IDLE next cycle. FlushF during an LSU transaction → response delivered normally.
- RspReady held low for 5 cycles → RspValid and Rsp* stable throughout. Reset pulsed in RESP → RspValid=0 the next cycle, state IDLE.
